// File: rtl/tdc_pkg.sv
// tdc_pkg: shared TDC fine-time constants and thermometer generator state encoding
package tdc_pkg;
    localparam int N_TAPS     = 200;
    localparam int BIN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    typedef enum logic [1:0] {ST_STREAM, ST_DRAIN, ST_SWEEP} state_t;
endpackage

// File: rtl/thermo_fifo.sv
// thermo_fifo: synchronous FIFO holding tap codes plus bubble flags
module thermo_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign rd_data = mem_q[rd_ptr_q];
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    // storage needs no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/tdc_thermo_gen.sv
// tdc_thermo_gen: binary tap count to delay-line thermometer word generator with full-range sweep
module tdc_thermo_gen
    import tdc_pkg::*;
#(
    parameter int N_TAPS     = tdc_pkg::N_TAPS,
    parameter int BIN_W      = tdc_pkg::BIN_W,
    parameter int FIFO_DEPTH = tdc_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIN_W-1:0]  in_bin,
    input  logic              in_bubble,
    input  logic              sweep_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_TAPS-1:0] thermo_out,
    output logic              out_sat,
    output logic              sweep_busy,
    output logic              sweep_done
);
    localparam logic [BIN_W-1:0] CODE_MAX = BIN_W'(N_TAPS);
    state_t            state_q, state_d;
    logic              run_q, run_d;
    logic              out_valid_q, out_valid_d, sat_q, sat_d, done_q, done_d;
    logic [N_TAPS-1:0] thermo_q, thermo_d;
    logic [BIN_W-1:0]  cnt_q, cnt_d, raw, code;
    logic [BIN_W:0]    fifo_rd;
    logic              fifo_full, fifo_empty, accept, out_free, out_fire;
    logic              load_fifo, load_sweep, load, sat, bub, done;
    // run_q keeps in_ready low until the first clock after reset release
    assign in_ready   = run_q && state_q == ST_STREAM && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign thermo_out = thermo_q;
    assign out_sat    = sat_q;
    assign sweep_busy = state_q != ST_STREAM;
    assign sweep_done = done_q;
    thermo_fifo #(.W(BIN_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .pop     (load_fifo),
        .wr_data ({in_bubble, in_bin}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
    always_comb begin
        out_fire    = out_valid_q && out_ready;
        out_free    = !out_valid_q || out_ready;
        load_fifo   = state_q != ST_SWEEP && !fifo_empty && out_free;
        load_sweep  = state_q == ST_SWEEP && out_free && cnt_q <= CODE_MAX;
        load        = load_fifo || load_sweep;
        raw         = load_sweep ? cnt_q : fifo_rd[BIN_W-1:0];
        sat         = raw > CODE_MAX;
        code        = sat ? CODE_MAX : raw;
        bub         = load_fifo && fifo_rd[BIN_W] && code >= BIN_W'(3);
        for (int k = 0; k < N_TAPS; k++)
            thermo_d[k] = load ? (k < int'(code) && !(bub && k == int'(code) - 2)) : thermo_q[k];
        sat_d       = load ? sat : sat_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        // cnt_q is one past the last issued code, so N_TAPS+1 means the final word is out
        done        = state_q == ST_SWEEP && out_fire && cnt_q == BIN_W'(N_TAPS + 1);
        done_d      = done;
        cnt_d       = state_q == ST_SWEEP ? cnt_q + BIN_W'(load_sweep) : '0;
        run_d       = 1'b1;
        state_d     = state_q == ST_STREAM ?
                          (sweep_start ? ((!fifo_empty || out_valid_q || accept) ? ST_DRAIN : ST_SWEEP) : ST_STREAM) :
                      state_q == ST_DRAIN ? ((fifo_empty && out_free) ? ST_SWEEP : ST_DRAIN) :
                      (done ? ST_STREAM : ST_SWEEP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STREAM;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            thermo_q    <= '0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            thermo_q    <= thermo_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
